// File: rtl/key_cmd_sched.sv
// key_cmd_sched
// Converts four debounced active-low button lines into discrete game commands.
// Every press yields one command. Keys enabled in REPEAT_MASK auto-repeat
// while held: first after DELAY_TICKS ticks, then every RATE_TICKS ticks.
// Commands wait in a per-key pending vector and are issued lowest index
// first through a registered valid/ready output port.

module key_cmd_sched #(
  parameter int         TICK_DIV    = 50000,
  parameter int         DELAY_TICKS = 200,
  parameter int         RATE_TICKS  = 50,
  parameter logic [3:0] REPEAT_MASK = 4'b1110
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] key_in,
  input  logic       en,
  input  logic       cmd_ready,
  output logic       cmd_valid,
  output logic [1:0] cmd_id,
  output logic [3:0] held
);

  // Prescaler width: TICK_DIV >= 2, so the width is always at least 1 bit.
  localparam int             PW         = $clog2(TICK_DIV);
  localparam logic [PW-1:0]  PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0]  PRESC_ONE  = PW'(1'b1);
  localparam logic [7:0]     DELAY_LAST = 8'(DELAY_TICKS);
  localparam logic [7:0]     RATE_LAST  = 8'(RATE_TICKS);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2
  } key_state_t;

  // Prescaler and tick
  logic [PW-1:0] presc_r;
  logic          tick_s;

  // Edge detection
  logic [3:0]    key_q_r;
  logic [3:0]    press_s;

  // Per-key repeat machines
  key_state_t    state_r     [4];
  key_state_t    state_nxt_s [4];
  logic [7:0]    cnt_r       [4];
  logic [7:0]    cnt_nxt_s   [4];
  logic [3:0]    evt_s;

  // Pending vector and output arbitration
  logic [3:0]    pend_r;
  logic [3:0]    pend_nxt_s;
  logic [3:0]    pend_clr_s;
  logic          pend_any_s;
  logic [1:0]    pick_id_s;
  logic          load_s;

  assign tick_s  = (presc_r == PRESC_LAST);
  assign press_s = key_q_r & ~key_in;

  // Free-running prescaler; wraps at TICK_DIV-1 independent of en.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_r <= '0;
    end else if (tick_s) begin
      presc_r <= '0;
    end else begin
      presc_r <= presc_r + PRESC_ONE;
    end
  end

  // Key history for press detection and the held mirror; reset to
  // "released" so a key held through reset is seen as a fresh press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_q_r <= 4'b1111;
      held    <= 4'b0000;
    end else begin
      key_q_r <= key_in;
      held    <= ~key_in;
    end
  end

  // Per-key next state: release wins over everything, a press starts the
  // delay phase, ticks advance the counter and fire repeats.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      state_nxt_s[k] = state_r[k];
      cnt_nxt_s[k]   = cnt_r[k];
      evt_s[k]       = 1'b0;
      if (key_in[k]) begin
        state_nxt_s[k] = ST_IDLE;
        cnt_nxt_s[k]   = 8'd0;
      end else begin
        case (state_r[k])
          ST_IDLE: begin
            if (press_s[k]) begin
              // A tick coinciding with the press edge is deliberately ignored.
              state_nxt_s[k] = ST_DELAY;
              cnt_nxt_s[k]   = 8'd0;
              evt_s[k]       = 1'b1;
            end else begin
              state_nxt_s[k] = ST_IDLE;
            end
          end
          ST_DELAY: begin
            if (tick_s) begin
              if ((cnt_r[k] + 8'd1) == DELAY_LAST) begin
                state_nxt_s[k] = ST_REPEAT;
                cnt_nxt_s[k]   = 8'd0;
                evt_s[k]       = REPEAT_MASK[k];
              end else begin
                cnt_nxt_s[k]   = cnt_r[k] + 8'd1;
              end
            end else begin
              cnt_nxt_s[k] = cnt_r[k];
            end
          end
          ST_REPEAT: begin
            if (tick_s) begin
              if ((cnt_r[k] + 8'd1) == RATE_LAST) begin
                cnt_nxt_s[k] = 8'd0;
                evt_s[k]     = REPEAT_MASK[k];
              end else begin
                cnt_nxt_s[k] = cnt_r[k] + 8'd1;
              end
            end else begin
              cnt_nxt_s[k] = cnt_r[k];
            end
          end
          default: begin
            state_nxt_s[k] = ST_IDLE;
            cnt_nxt_s[k]   = 8'd0;
          end
        endcase
      end
    end
  end

  // Per-key state and tick counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 4; k++) begin
        state_r[k] <= ST_IDLE;
        cnt_r[k]   <= 8'd0;
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        state_r[k] <= state_nxt_s[k];
        cnt_r[k]   <= cnt_nxt_s[k];
      end
    end
  end

  // Lowest-index pending key wins the output register.
  always_comb begin
    pend_any_s = (pend_r != 4'b0000);
    casez (pend_r)
      4'b???1: pick_id_s = 2'd0;
      4'b??10: pick_id_s = 2'd1;
      4'b?100: pick_id_s = 2'd2;
      4'b1000: pick_id_s = 2'd3;
      default: pick_id_s = 2'd0;
    endcase
  end

  // Pending update: arbitration uses the pre-event vector, so an event on
  // the key being loaded this cycle survives as a new pending bit.
  always_comb begin
    load_s = !cmd_valid || cmd_ready;
    if (load_s && pend_any_s) begin
      pend_clr_s = 4'b0001 << pick_id_s;
    end else begin
      pend_clr_s = 4'b0000;
    end
    if (en) begin
      pend_nxt_s = (pend_r & ~pend_clr_s) | evt_s;
    end else begin
      pend_nxt_s = 4'b0000;
    end
  end

  // Pending vector register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_r <= 4'b0000;
    end else begin
      pend_r <= pend_nxt_s;
    end
  end

  // Output register: reloads whenever empty or being accepted; cmd_id is
  // frozen while a command waits for cmd_ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_valid <= 1'b0;
      cmd_id    <= 2'd0;
    end else if (load_s) begin
      cmd_valid <= pend_any_s;
      if (pend_any_s) begin
        cmd_id <= pick_id_s;
      end else begin
        cmd_id <= cmd_id;
      end
    end else begin
      cmd_valid <= cmd_valid;
      cmd_id    <= cmd_id;
    end
  end

endmodule
